pulp_clk_gate_ctrl: RTL and testbench

- Per-domain clock-gate sequencer. Drives the en_i inputs of the pulp_clock_gating cells, one cell per domain.
- Watches each domain's busy/wake activity and counts idle cycles.
- Runs a request/acknowledge handshake with the domain before gating its clock.
- Re-enables the clock on wake, then waits a fixed settle time before counting idle again.

---
 rtl/pulp_clk_gate_ctrl.sv | 108 ++++++++++
 tb/tb_pulp_clk_gate_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pulp_clk_gate_ctrl.sv
// Per-domain clock-gate sequencer: counts idle cycles, handshakes a gate request,
// gates the domain clock and re-enables it on wake with a fixed settle period.
module pulp_clk_gate_ctrl #(
    parameter int N_DOMAINS   = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_en_i,
    input  logic [N_DOMAINS-1:0] cfg_enable_i,
    input  logic [CNT_WIDTH-1:0] idle_thresh_i,
    input  logic [N_DOMAINS-1:0] busy_i,
    input  logic [N_DOMAINS-1:0] wake_i,
    input  logic [N_DOMAINS-1:0] gate_ack_i,
    output logic [N_DOMAINS-1:0] gate_req_o,
    output logic [N_DOMAINS-1:0] clk_en_o,
    output logic [N_DOMAINS-1:0] gated_o
);

    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_REQ,
        ST_GATED,
        ST_WAKE
    } state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Shared threshold decode: a zero threshold disables gating everywhere.
    logic                 thresh_on;
    logic [CNT_WIDTH-1:0] thresh_m1;
    assign thresh_on = |idle_thresh_i;
    assign thresh_m1 = idle_thresh_i - CNT_WIDTH'(1);

    logic [N_DOMAINS-1:0] state_en;

    for (genvar d = 0; d < N_DOMAINS; d++) begin : g_dom
        state_e               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [WW-1:0]        wcnt_q, wcnt_d;
        logic                 idle, abort;

        assign idle  = cfg_enable_i[d] & ~busy_i[d] & ~wake_i[d];
        assign abort = busy_i[d] | wake_i[d] | ~cfg_enable_i[d];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_ACTIVE;
                cnt_q   <= '0;
                wcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wcnt_q  <= wcnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            wcnt_d  = '0;
            unique case (state_q)
                ST_ACTIVE: begin
                    if (thresh_on && idle && (cnt_q >= thresh_m1)) begin
                        state_d = ST_REQ;
                    end else if (idle) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                // Abort wins over a same-cycle acknowledge.
                ST_REQ: begin
                    if (abort) begin
                        state_d = ST_ACTIVE;
                    end else if (gate_ack_i[d]) begin
                        state_d = ST_GATED;
                    end
                end
                ST_GATED: begin
                    if (abort) begin
                        state_d = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (wcnt_q == WAKE_LAST) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        wcnt_d = wcnt_q + WW'(1);
                    end
                end
                default: state_d = ST_ACTIVE;
            endcase
        end

        // Outputs come from registered state only so the gating latch sees a stable enable.
        assign state_en[d]   = (state_q != ST_GATED);
        assign gate_req_o[d] = (state_q == ST_REQ);
        assign gated_o[d]    = (state_q == ST_GATED);
    end

    assign clk_en_o = state_en | {N_DOMAINS{test_en_i}};

endmodule

// File: tb/tb_pulp_clk_gate_ctrl.sv
// Randomized bench for pulp_clk_gate_ctrl against a behavioural per-domain model.
module tb_pulp_clk_gate_ctrl;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int WC = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_en = 1'b0;
    logic [N-1:0]  cfg_enable = '1;
    logic [CW-1:0] idle_thresh = 8'd4;
    logic [N-1:0]  busy = '0;
    logic [N-1:0]  wake = '0;
    logic [N-1:0]  gate_ack = '0;
    logic [N-1:0]  gate_req;
    logic [N-1:0]  clk_en;
    logic [N-1:0]  gated;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: run length of idle cycles, request/off flags and remaining settle cycles.
    int m_run   [N];
    bit m_ask   [N];
    bit m_off   [N];
    int m_settle[N];

    always #5 clk = ~clk;

    pulp_clk_gate_ctrl #(
        .N_DOMAINS  (N),
        .CNT_WIDTH  (CW),
        .WAKE_CYCLES(WC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .test_en_i    (test_en),
        .cfg_enable_i (cfg_enable),
        .idle_thresh_i(idle_thresh),
        .busy_i       (busy),
        .wake_i       (wake),
        .gate_ack_i   (gate_ack),
        .gate_req_o   (gate_req),
        .clk_en_o     (clk_en),
        .gated_o      (gated)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_run[d] = 0; m_ask[d] = 0; m_off[d] = 0; m_settle[d] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < N; d++) begin
            bit idle, abort;
            idle  = cfg_enable[d] && !busy[d] && !wake[d];
            abort = busy[d] || wake[d] || !cfg_enable[d];
            if (m_settle[d] > 0) begin
                m_settle[d]--;
                m_run[d] = 0;
            end else if (m_off[d]) begin
                if (abort) begin
                    m_off[d] = 0;
                    m_settle[d] = WC;
                end
            end else if (m_ask[d]) begin
                if (abort) begin
                    m_ask[d] = 0;
                    m_run[d] = 0;
                end else if (gate_ack[d]) begin
                    m_ask[d] = 0;
                    m_off[d] = 1;
                end
            end else if (idle_thresh != 0 && idle && m_run[d] + 1 >= int'(idle_thresh)) begin
                m_ask[d] = 1;
                m_run[d] = 0;
            end else begin
                m_run[d] = idle ? ((m_run[d] < CNT_MAX) ? m_run[d] + 1 : CNT_MAX) : 0;
            end
        end
    endtask

    task automatic compare_outputs(input string where);
        logic [N-1:0] e_req, e_en, e_gated;
        for (int d = 0; d < N; d++) begin
            e_req[d]   = m_ask[d];
            e_gated[d] = m_off[d];
            e_en[d]    = !m_off[d] || test_en;
        end
        check({where, ".gate_req"}, 32'(gate_req), 32'(e_req));
        check({where, ".clk_en"},   32'(clk_en),   32'(e_en));
        check({where, ".gated"},    32'(gated),    32'(e_gated));
    endtask

    task automatic run_phase(input int cycles, input int p_busy, input int p_wake,
                             input int p_ack, input int p_cfg_off, input logic [CW-1:0] thr);
        idle_thresh = thr;
        for (int c = 0; c < cycles; c++) begin
            for (int d = 0; d < N; d++) begin
                busy[d]       = ($urandom_range(99) < p_busy);
                wake[d]       = ($urandom_range(99) < p_wake);
                gate_ack[d]   = ($urandom_range(99) < p_ack);
                cfg_enable[d] = !($urandom_range(99) < p_cfg_off);
            end
            test_en = ($urandom_range(99) < 8);
            if ($urandom_range(99) < 3) idle_thresh = CW'($urandom_range(6));
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_outputs("rnd");
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        // Reset values with test mode off.
        compare_outputs("reset");
        rst_n = 1'b1;

        // Deterministic idle entry: four idle edges then a request.
        idle_thresh = 8'd4;
        for (int c = 0; c < 6; c++) begin
            gate_ack = (c == 5) ? 4'b0001 : 4'b0000;
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_outputs("entry");
        end

        for (int ph = 0; ph < 40; ph++) begin
            case (ph % 5)
                0: run_phase(60, 5, 3, 40, 0, 8'd4);
                1: run_phase(60, 20, 2, 30, 10, CW'($urandom_range(1, 3)));
                2: run_phase(60, 2, 8, 60, 3, 8'd1);
                3: run_phase(40, 3, 3, 50, 0, 8'd0);
                default: run_phase(60, 10, 5, 25, 20, CW'($urandom_range(0, 8)));
            endcase
            // Async reset dropped mid-cycle, away from any clock edge.
            if (ph % 4 == 3) begin
                test_en = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                compare_outputs("async_rst");
                @(posedge clk);
                @(negedge clk);
                compare_outputs("held_rst");
                rst_n = 1'b1;
            end
        end

        // Long idle with zero threshold saturates the count; threshold 255 then triggers.
        busy = '0; wake = '0; gate_ack = '0; cfg_enable = '1; test_en = 1'b0;
        idle_thresh = 8'd0;
        for (int c = 0; c < 300; c++) begin
            if (c == 290) idle_thresh = 8'hFF;
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_outputs("sat");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
